// File: rtl/alu_share_arbiter.sv
// Round-robin share of one execute-stage ALU between two requesters, with a
// single registered response slot and the architectural NZCV register.
// Optional feature macro: ALU_ARB_LOCK_EN (per-requester lock inputs).
module alu_share_arbiter #(
  parameter int unsigned CMD_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ST_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  input  logic [CMD_W-1:0]  i_req0_cmd,
  input  logic [DATA_W-1:0] i_req0_op1,
  input  logic [DATA_W-1:0] i_req0_op2,
  input  logic              i_req0_s,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [CMD_W-1:0]  i_req1_cmd,
  input  logic [DATA_W-1:0] i_req1_op1,
  input  logic [DATA_W-1:0] i_req1_op2,
  input  logic              i_req1_s,
  output logic              o_req1_ready,
`ifdef ALU_ARB_LOCK_EN
  input  logic              i_req0_lock,
  input  logic              i_req1_lock,
`endif
  output logic [CMD_W-1:0]  o_alu_command,
  output logic [DATA_W-1:0] o_alu_op1,
  output logic [DATA_W-1:0] o_alu_op2,
  output logic [ST_W-1:0]   o_alu_status_in,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [ST_W-1:0]   i_alu_status_bits,
  output logic              o_rsp_valid,
  output logic              o_rsp_id,
  output logic [DATA_W-1:0] o_rsp_result,
  output logic [ST_W-1:0]   o_rsp_status,
  input  logic              i_rsp_ready,
  output logic [ST_W-1:0]   o_status_reg
);

  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  state_t            r_state;
  logic              r_rr_last;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_result;
  logic [ST_W-1:0]   r_rsp_status;
  logic [ST_W-1:0]   r_status;

  logic w_can_issue;
  logic w_gnt_vld;
  logic w_gnt;
  logic w_lock_hold;
  logic w_gnt_s;

  // Reset term makes ready drop asynchronously with the rest of the state.
  assign w_can_issue = i_rst & ((r_state == S_IDLE) | i_rsp_ready);

`ifdef ALU_ARB_LOCK_EN
  assign w_lock_hold = r_rr_last ? (i_req1_lock & i_req1_valid)
                                 : (i_req0_lock & i_req0_valid);
`else
  assign w_lock_hold = 1'b0;
`endif

  // Grant selection: sole requester wins; on a tie the one not served last,
  // unless the last winner holds its lock.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = 1'b0;
    if (w_can_issue) begin
      if (i_req0_valid && i_req1_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_lock_hold ? r_rr_last : ~r_rr_last;
      end else if (i_req0_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt     = 1'b0;
      end else if (i_req1_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt     = 1'b1;
      end
    end
  end

  assign o_req0_ready = w_gnt_vld & ~w_gnt;
  assign o_req1_ready = w_gnt_vld &  w_gnt;

  always_comb begin
    o_alu_command = '0;
    o_alu_op1     = '0;
    o_alu_op2     = '0;
    w_gnt_s       = 1'b0;
    if (w_gnt_vld) begin
      o_alu_command = w_gnt ? i_req1_cmd : i_req0_cmd;
      o_alu_op1     = w_gnt ? i_req1_op1 : i_req0_op1;
      o_alu_op2     = w_gnt ? i_req1_op2 : i_req0_op2;
      w_gnt_s       = w_gnt ? i_req1_s   : i_req0_s;
    end
  end

  assign o_alu_status_in = r_status;

  // Slot FSM: a handshake always (re)loads the slot; otherwise a consumed slot empties.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_rr_last    <= 1'b1;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_status <= '0;
      r_status     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_gnt_vld) begin
            r_state      <= S_RESP;
            r_rsp_id     <= w_gnt;
            r_rr_last    <= w_gnt;
            r_rsp_result <= i_alu_result;
            r_rsp_status <= i_alu_status_bits;
            if (w_gnt_s) begin
              r_status <= i_alu_status_bits;
            end
          end else if (r_state == S_RESP && i_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_valid  = (r_state == S_RESP);
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_status = r_rsp_status;
  assign o_status_reg = r_status;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small reference ALU on the ALU ports.
// Define ALU_ARB_LOCK_EN to also exercise the lock inputs.
module tb_alu_share_arbiter;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ST_W   = 4;

  localparam logic [CMD_W-1:0] C_ADD = 4'h0;
  localparam logic [CMD_W-1:0] C_SUB = 4'h1;
  localparam logic [CMD_W-1:0] C_ADC = 4'h2;
  localparam logic [CMD_W-1:0] C_SBC = 4'h3;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_s, req0_ready;
  logic req1_valid, req1_s, req1_ready;
  logic [CMD_W-1:0]  req0_cmd, req1_cmd, alu_command;
  logic [DATA_W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [DATA_W-1:0] alu_op1, alu_op2, alu_result, rsp_result;
  logic [ST_W-1:0]   alu_status_in, alu_status_bits, rsp_status, status_reg;
  logic rsp_valid, rsp_id, rsp_ready;
  logic req0_lock, req1_lock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.CMD_W(CMD_W), .DATA_W(DATA_W), .ST_W(ST_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .i_req0_cmd(req0_cmd), .i_req0_op1(req0_op1),
    .i_req0_op2(req0_op2), .i_req0_s(req0_s), .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid), .i_req1_cmd(req1_cmd), .i_req1_op1(req1_op1),
    .i_req1_op2(req1_op2), .i_req1_s(req1_s), .o_req1_ready(req1_ready),
`ifdef ALU_ARB_LOCK_EN
    .i_req0_lock(req0_lock), .i_req1_lock(req1_lock),
`endif
    .o_alu_command(alu_command), .o_alu_op1(alu_op1), .o_alu_op2(alu_op2),
    .o_alu_status_in(alu_status_in), .i_alu_result(alu_result),
    .i_alu_status_bits(alu_status_bits),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_result(rsp_result),
    .o_rsp_status(rsp_status), .i_rsp_ready(rsp_ready), .o_status_reg(status_reg)
  );

  // Reference ALU, flags ordered {N,Z,C,V}; C is the ARM-style not-borrow on subtract.
  logic [DATA_W:0]   m_sum;
  logic [DATA_W-1:0] m_b;
  logic              m_cin;
  always_comb begin
    m_b   = '0;
    m_cin = 1'b0;
    case (alu_command)
      C_ADD: begin m_b = alu_op2;  m_cin = 1'b0;             end
      C_ADC: begin m_b = alu_op2;  m_cin = alu_status_in[1]; end
      C_SUB: begin m_b = ~alu_op2; m_cin = 1'b1;             end
      C_SBC: begin m_b = ~alu_op2; m_cin = alu_status_in[1]; end
      default: begin m_b = '0; m_cin = 1'b0; end
    endcase
    m_sum = {1'b0, alu_op1} + {1'b0, m_b} + (DATA_W+1)'(m_cin);
    alu_result = m_sum[DATA_W-1:0];
    alu_status_bits = {m_sum[DATA_W-1], (m_sum[DATA_W-1:0] == '0), m_sum[DATA_W],
                       (alu_op1[DATA_W-1] == m_b[DATA_W-1]) &&
                       (m_sum[DATA_W-1] != alu_op1[DATA_W-1])};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 0; req0_cmd = '0; req0_op1 = '0; req0_op2 = '0; req0_s = 0;
    req1_valid = 0; req1_cmd = '0; req1_op1 = '0; req1_op2 = '0; req1_s = 0;
    req0_lock = 0; req1_lock = 0; rsp_ready = 0;

    // Reset values; ready held low even with a request present.
    #2;
    req0_valid = 1;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_rsp_status", 64'(rsp_status), 64'd0);
    chk("rst_status_reg", 64'(status_reg), 64'd0);
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    req0_valid = 0;
    #9 rst = 1'b1;
    tick();

    // req0 ADD 5+7 with flag commit
    req0_valid = 1; req0_cmd = C_ADD; req0_op1 = 5; req0_op2 = 7; req0_s = 1;
    rsp_ready = 1;
    #1;
    chk("add_req0_ready", 64'(req0_ready), 64'd1);
    chk("add_req1_ready", 64'(req1_ready), 64'd0);
    chk("add_alu_op1", 64'(alu_op1), 64'd5);
    tick();
    req0_valid = 0;
    chk("add_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("add_rsp_id", 64'(rsp_id), 64'd0);
    chk("add_rsp_result", 64'(rsp_result), 64'd12);
    chk("add_status_reg", 64'(status_reg), 64'h0);
    tick();
    chk("drain_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("drain_rsp_hold", 64'(rsp_result), 64'd12);

    // Both requesting; req0 served last, so req1 leads and grants alternate.
    req0_valid = 1; req0_cmd = C_SUB; req0_op1 = 1; req0_op2 = 1; req0_s = 0;
    req1_valid = 1; req1_cmd = C_ADD; req1_op1 = 2; req1_op2 = 2; req1_s = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_req1_ready", 64'(req1_ready), 64'((i % 2) == 0));
      chk("rr_req0_ready", 64'(req0_ready), 64'((i % 2) == 1));
      tick();
      chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rr_rsp_id", 64'(rsp_id), 64'((i % 2) == 0));
      chk("rr_rsp_result", 64'(rsp_result), ((i % 2) == 0) ? 64'd4 : 64'd0);
      chk("rr_rsp_status", 64'(rsp_status), ((i % 2) == 0) ? 64'h0 : 64'h6);
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_no_commit", 64'(status_reg), 64'h0);
    tick();

    // req1 SUB 3-3 commits Z,C; the following ADC sees C=1.
    req1_valid = 1; req1_cmd = C_SUB; req1_op1 = 3; req1_op2 = 3; req1_s = 1;
    tick();
    chk("sub_status_reg", 64'(status_reg), 64'h6);
    chk("sub_rsp_result", 64'(rsp_result), 64'd0);
    req1_cmd = C_ADC; req1_op1 = 0; req1_op2 = 0;
    #1;
    chk("adc_alu_status_in", 64'(alu_status_in), 64'h6);
    chk("adc_req1_ready", 64'(req1_ready), 64'd1);
    tick();
    chk("adc_rsp_result", 64'(rsp_result), 64'd1);
    chk("adc_rsp_id", 64'(rsp_id), 64'd1);
    chk("adc_status_reg", 64'(status_reg), 64'h0);

    // Backpressure: slot held, req0 stalled, then issues the cycle rsp_ready rises.
    req1_valid = 0; rsp_ready = 0;
    req0_valid = 1; req0_cmd = C_ADD; req0_op1 = 10; req0_op2 = 20; req0_s = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req0_ready", 64'(req0_ready), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_result", 64'(rsp_result), 64'd1);
      chk("bp_rsp_id", 64'(rsp_id), 64'd1);
      tick();
    end
    rsp_ready = 1;
    #1;
    chk("bp_release_ready", 64'(req0_ready), 64'd1);
    tick();
    chk("bp_rsp_result2", 64'(rsp_result), 64'd30);
    chk("bp_rsp_id2", 64'(rsp_id), 64'd0);

    // Signed overflow boundary: 0x7fffffff + 1 sets N and V.
    req0_op1 = 32'h7fff_ffff; req0_op2 = 1; req0_s = 1;
    tick();
    chk("ovf_rsp_result", 64'(rsp_result), 64'h8000_0000);
    chk("ovf_rsp_status", 64'(rsp_status), 64'h9);
    chk("ovf_status_reg", 64'(status_reg), 64'h9);

    // Asynchronous reset while the slot is full.
    rsp_ready = 0; req1_valid = 1; req1_cmd = C_ADD; req1_s = 0;
    #2 rst = 1'b0;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_status_reg", 64'(status_reg), 64'h0);
    chk("arst_rsp_result", 64'(rsp_result), 64'd0);
    chk("arst_req0_ready", 64'(req0_ready), 64'd0);
    chk("arst_req1_ready", 64'(req1_ready), 64'd0);
    #1 rst = 1'b1;
    rsp_ready = 1;
    #1;
    chk("post_rst_req0_wins", 64'(req0_ready), 64'd1);
    chk("post_rst_req1_wait", 64'(req1_ready), 64'd0);
    tick();
    chk("post_rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd1);

`ifdef ALU_ARB_LOCK_EN
    // req0 was last winner and holds its lock: it keeps the ALU despite req1.
    req0_lock = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lock_req0_ready", 64'(req0_ready), 64'd1);
      tick();
      chk("lock_rsp_id", 64'(rsp_id), 64'd0);
    end
    req0_lock = 0;
    #1;
    chk("unlock_req1_ready", 64'(req1_ready), 64'd1);
    tick();
    chk("unlock_rsp_id", 64'(rsp_id), 64'd1);
`endif

    req0_valid = 0; req1_valid = 0;
    tick();
    chk("end_idle", 64'(rsp_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
